// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and output saturation
// for the time-multiplexed FIR filter bank.
package fir_pkg;

    localparam int NTAPS      = 31;
    localparam int HIST_DEPTH = 32;
    localparam int IDX_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_EMIT
    } fir_state_e;

    // Clamp a sign-extended accumulator to a y_w-bit signed range.
    function automatic logic signed [63:0] sat_acc(
        input logic signed [63:0] acc,
        input int                 y_w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (y_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (y_w - 1));
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fir_bank_sequencer_history.sv
// 32-entry circular sample history; wp marks the newest sample
// and reads are addressed as an age offset from it.
module fir_history_buf
    import fir_pkg::*;
#(
    parameter int X_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic signed [X_W-1:0] x,
    input  logic [IDX_W-1:0]      k,
    output logic signed [X_W-1:0] rdata
);

    logic [IDX_W-1:0]      wp_q;
    logic [IDX_W-1:0]      wp_d;
    logic signed [X_W-1:0] mem_q [HIST_DEPTH];

    assign wp_d = wp_q + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            wp_q        <= wp_d;
            mem_q[wp_d] <= x;
        end
    end

    // 5-bit subtraction wraps naturally around the ring.
    assign rdata = mem_q[wp_q - k];

endmodule

// File: rtl/fir_bank_sequencer.sv
// Shares one MAC across the filter bank: 31 tap cycles plus one
// emit cycle per filter for every accepted input sample.
module fir_bank_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_FILTERS = 2,
    parameter int X_W         = 8,
    parameter int C_W         = 10,
    parameter int ACC_W       = 24,
    parameter int Y_W         = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready,
    input  logic signed [X_W-1:0] x,
    output logic [1:0]            filter_sel,
    output logic [IDX_W-1:0]      coeff_index,
    input  logic signed [C_W-1:0] coeff,
    output logic signed [Y_W-1:0] y,
    output logic                  y_valid,
    output logic [1:0]            y_filter,
    output logic                  busy,
    output logic                  overrun
);

    localparam int P_W = X_W + C_W;

    fir_state_e              state_q, state_d;
    logic [1:0]              filt_q, filt_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [Y_W-1:0]   y_q, y_d;
    logic                    yv_q, yv_d;
    logic [1:0]              yf_q, yf_d;
    logic                    ovr_q, ovr_d;
    logic                    accept;

    logic signed [X_W-1:0]   tap;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [63:0]      acc_wide;
    logic signed [63:0]      acc_sat;
    logic                    last_tap;
    logic                    last_filt;

    fir_history_buf #(
        .X_W(X_W)
    ) u_hist (
        .clock(clock),
        .reset(reset),
        .we   (accept),
        .x    (x),
        .k    (k_q),
        .rdata(tap)
    );

    assign prod      = tap * coeff;
    assign prod_ext  = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    assign acc_wide  = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign acc_sat   = sat_acc(acc_wide, Y_W);
    assign last_tap  = (k_q == IDX_W'(NTAPS - 1));
    assign last_filt = (filt_q == 2'(NUM_FILTERS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            filt_q  <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            yf_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            yf_q    <= yf_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        k_d     = k_q;
        acc_d   = acc_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        yf_d    = yf_q;
        ovr_d   = ovr_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    accept  = 1'b1;
                    state_d = ST_MAC;
                    filt_d  = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext;
                if (last_tap) begin
                    state_d = ST_EMIT;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
                if (ready) begin
                    ovr_d = 1'b1;
                end
            end
            ST_EMIT: begin
                y_d   = acc_sat[Y_W-1:0];
                yf_d  = filt_q;
                yv_d  = 1'b1;
                k_d   = '0;
                acc_d = '0;
                // A sample landing on the final emit starts a new pass.
                if (last_filt) begin
                    filt_d = '0;
                    if (ready) begin
                        accept  = 1'b1;
                        state_d = ST_MAC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    filt_d  = filt_q + 2'd1;
                    state_d = ST_MAC;
                    if (ready) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign filter_sel  = filt_q;
    assign coeff_index = k_q;
    assign y           = y_q;
    assign y_valid     = yv_q;
    assign y_filter    = yf_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_fir_bank_sequencer.sv
// Directed bench for fir_bank_sequencer with behavioural coefficient ROMs.
module tb_fir_bank_sequencer;

    logic               clock;
    logic               reset;
    logic               ready;
    logic signed [7:0]  x;
    logic [1:0]         filter_sel;
    logic [4:0]         coeff_index;
    logic signed [9:0]  coeff;
    logic signed [17:0] y;
    logic               y_valid;
    logic [1:0]         y_filter;
    logic               busy;
    logic               overrun;

    int  total = 0;
    int  bad   = 0;
    bit  stub  = 0;
    int  rom0 [32];
    int  rom1 [32];

    fir_bank_sequencer #(
        .NUM_FILTERS(2),
        .X_W(8),
        .C_W(10),
        .ACC_W(24),
        .Y_W(18)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .x          (x),
        .filter_sel (filter_sel),
        .coeff_index(coeff_index),
        .coeff      (coeff),
        .y          (y),
        .y_valid    (y_valid),
        .y_filter   (y_filter),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    always_comb begin
        coeff = '0;
        if (stub) begin
            coeff = 10'sd511;
        end else if (filter_sel == 2'd1) begin
            coeff = 10'(rom1[coeff_index]);
        end else begin
            coeff = 10'(rom0[coeff_index]);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        ready = 0;
        x     = 0;
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    // One sample pass; pulses must land 32 and 64 edges after acceptance.
    task automatic run(input int xv, input bit issue, input int ey0,
                       input int ey1, input int ncyc, input int extra_at,
                       input int extra_x);
        int np;
        np = 0;
        if (issue) begin
            ready = 1;
            x     = 8'(xv);
            @(posedge clock);
            #1;
        end
        for (int c = 1; c <= ncyc; c++) begin
            ready = (c == extra_at);
            x     = (c == extra_at) ? 8'(extra_x) : 8'sd0;
            @(posedge clock);
            #1;
            if (c == 5) begin
                check("kidx0", coeff_index, 5);
                check("fsel0", filter_sel, 0);
            end
            if (c == 40) begin
                check("kidx1", coeff_index, 8);
                check("fsel1", filter_sel, 1);
            end
            if (c == 70 && extra_at == 0) check("idle", busy, 0);
            if (y_valid) begin
                if (np == 0) begin
                    check("t0", c, 32);
                    check("yf0", y_filter, 0);
                    check("y0", y, ey0);
                end else if (np == 1) begin
                    check("t1", c, 64);
                    check("yf1", y_filter, 1);
                    check("y1", y, ey1);
                end else begin
                    check("extra_pulse", c, 0);
                end
                np++;
            end
        end
        ready = 0;
        x     = 0;
        check("npulse", np, 2);
    endtask

    function automatic int model(input int f, input int n, input int h[40]);
        int s;
        s = 0;
        for (int k = 0; k < 31; k++) begin
            if (n - k >= 0) s += (f == 1 ? rom1[k] : rom0[k]) * h[n-k];
        end
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        return s;
    endfunction

    initial begin
        int h[40];
        int e;
        int np;
        rom0 = '{2, 3, 3, 2, 0, -4, -9, -13, -14, -9, 2, 19, 40, 61, 78,
                 85,
                 78, 61, 40, 19, 2, -9, -14, -13, -9, -4, 0, 2, 3, 3, 2,
                 0};
        rom1 = '{-5, -4, -4, -3, -1, 4, 11, 20, 31, 44, 58, 72, 86, 98, 106,
                 109,
                 106, 98, 86, 72, 58, 44, 31, 20, 11, 4, -1, -3, -4, -4, -5,
                 0};
        reset = 1;
        ready = 0;
        x     = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_y", y, 0);
        check("rst_yv", y_valid, 0);
        check("rst_yf", y_filter, 0);
        check("rst_fsel", filter_sel, 0);
        check("rst_kidx", coeff_index, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        reset = 0;

        // impulse reproduces both tables
        for (int n = 0; n < 31; n++) begin
            run(n == 0 ? 1 : 0, 1, rom0[n], rom1[n], 80, 0, 0);
        end
        check("imp_ovr", overrun, 0);

        // saturation with all-511 coefficients
        stub = 1;
        do_reset();
        for (int n = 0; n < 31; n++) begin
            e = 64897 * (n + 1);
            if (e > 131071) e = 131071;
            run(127, 1, e, e, 80, 0, 0);
        end
        do_reset();
        for (int n = 0; n < 31; n++) begin
            e = -65408 * (n + 1);
            if (e < -131072) e = -131072;
            run(-128, 1, e, e, 80, 0, 0);
        end
        stub = 0;

        // dropped sample sets sticky overrun, history untouched
        do_reset();
        run(1, 1, rom0[0], rom1[0], 80, 10, 55);
        check("ovr_set", overrun, 1);
        run(0, 1, rom0[1], rom1[1], 80, 0, 0);
        check("ovr_sticky", overrun, 1);
        do_reset();
        check("ovr_clr", overrun, 0);

        // back-to-back: ready on the final emit cycle
        run(1, 1, rom0[0], rom1[0], 64, 64, 0);
        check("b2b_busy", busy, 1);
        check("b2b_ovr", overrun, 0);
        run(0, 0, rom0[1], rom1[1], 80, 0, 0);
        check("b2b_ovr2", overrun, 0);

        // reset in the middle of filter 0
        do_reset();
        run(1, 1, rom0[0], rom1[0], 80, 0, 0);
        ready = 1;
        x     = 1;
        @(posedge clock);
        #1;
        ready = 0;
        x     = 0;
        repeat (14) @(posedge clock);
        #1;
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        check("mid_y", y, 0);
        check("mid_yv", y_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_kidx", coeff_index, 0);
        check("mid_fsel", filter_sel, 0);
        np = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clock);
            #1;
            if (y_valid) np++;
        end
        check("mid_nopulse", np, 0);
        for (int n = 0; n < 3; n++) begin
            run(n == 0 ? 1 : 0, 1, rom0[n], rom1[n], 80, 0, 0);
        end

        // ramp across the pointer wrap
        do_reset();
        for (int n = 0; n < 40; n++) h[n] = n % 128;
        for (int n = 0; n < 40; n++) begin
            run(h[n], 1, model(0, n, h), model(1, n, h), 80, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_bank_sequencer.md
Name: fir_bank_sequencer

Overview:
Time-multiplexed FIR controller for the audio filter bank. It keeps a 32-entry circular history of input samples and walks one shared multiply-accumulate across NUM_FILTERS filters per input sample. It drives the select and index inputs of the external combinational coefficient ROMs (the 31-tap 10-bit bandpass tables) and emits one saturated result per filter. It sits between the ADC sample strobe and the downstream envelope/detection logic.

Parameters:
NUM_FILTERS, 2, number of filters sharing the MAC (1..4)
NTAPS, 31, taps per filter (fixed 31; index 0..30)
X_W, 8, signed input sample width
C_W, 10, signed coefficient width
ACC_W, 24, signed accumulator width
Y_W, 18, signed output width after saturation

Ports:
clock  in  1  system clock; the single clock
reset  in  1  synchronous, active-high reset
ready  in  1  one-cycle new-sample strobe
x  in  X_W  signed sample, valid when ready=1
filter_sel  out  2  selects which coefficient ROM feeds coeff
coeff_index  out  5  tap index to the coefficient ROM
coeff  in  C_W  signed ROM output, combinational from filter_sel/coeff_index in the same cycle
y  out  Y_W  signed saturated filter output
y_valid  out  1  one-cycle pulse when y is valid
y_filter  out  2  filter number that y belongs to
busy  out  1  high whenever the FSM is not in IDLE
overrun  out  1  sticky flag: a sample was dropped

Behaviour:
- Reset (synchronous, active-high), all values cleared in one cycle:
  - y=0, y_valid=0, y_filter=0, filter_sel=0, coeff_index=0, busy=0, overrun=0
  - write pointer wp=0, accumulator=0, all 32 history entries=0
  - FSM goes to IDLE
  - Reset also aborts any MAC in progress; no y_valid follows.
- History buffer: 32 x X_W registers; wp points at the newest sample.
  - Accept: wp <= wp+1 (mod 32), buf[wp+1] <= x.
  - The tap k operand is buf[(wp-k) mod 32]; 5-bit wrap is natural.
- FSM states: IDLE, MAC, EMIT.
  - IDLE: on ready, accept the sample, then go to MAC with filter=0, k=0, acc=0.
  - MAC: coeff_index=k, filter_sel=filter.
    - Each cycle: acc <= acc + sext(coeff * buf[wp-k]).
    - The product is a full X_W+C_W signed multiply (18 bits).
    - k=NTAPS-1 moves to EMIT; otherwise k <= k+1.
  - EMIT: y <= sat(acc), y_filter <= filter, y_valid=1 for this cycle only. Then:
    - If filter=NUM_FILTERS-1: go to IDLE.
    - Else: filter <= filter+1, k=0, acc=0, go to MAC.
- Saturation: acc > 2^(Y_W-1)-1 gives 131071; acc < -2^(Y_W-1) gives -131072; otherwise acc[Y_W-1:0].
- Latency: 32 cycles per filter (31 MAC + 1 EMIT).
  - First y_valid comes 32 cycles after the ready cycle.
  - Filter f's result comes 32*(f+1) cycles after ready.
  - Busy window is NUM_FILTERS*32 cycles.
- ready while busy (MAC, or EMIT of a non-last filter): the sample is dropped, overrun <= 1 (sticky until reset), and history is unchanged.
- ready during EMIT of the last filter: the sample is accepted. The FSM goes straight to MAC (filter=0) with no idle cycle; overrun is not set. y_valid for the last filter still pulses in this cycle.
- ready has no effect on the MAC in progress.
- y holds its last value between pulses.

Decomposition:
- Shared package fir_pkg:
  - localparams NTAPS=31, HIST_DEPTH=32, IDX_W=5
  - FSM state encoding (IDLE/MAC/EMIT)
  - the saturation function (ACC_W to Y_W)
- One natural sub-module, fir_history_buf: the 32-entry circular register file.
  - Ports: clock, reset, write strobe, x, offset k, read data.
  - Holds wp internally.
- Coefficient ROMs stay external. A top-level mux on filter_sel selects among the ROM outputs onto coeff.

Test Plan:
- Impulse: real ROMs; ready with x=1, then x=0 samples spaced 80 cycles apart. Filter-1 y over 31 samples reproduces its table: -5,-4,-4,-3,-1,4,11,...,109,...,-5. y_filter alternates 0,1. y_valid fires exactly 32 and 64 cycles after each ready.
- Saturation: stub ROM with all coeffs=511, repeated x=127 (31 samples) gives y=131071. With x=-128 it gives y=-131072. Intermediate partial sums check the acc[17:0] passthrough.
- Overrun: a second ready 10 cycles after the first is dropped and overrun=1. Outputs match a single-sample run, and overrun stays 1 until reset.
- Back-to-back: ready exactly in the last EMIT cycle (cycle 64 after the previous ready). The sample is accepted, busy stays 1, overrun stays 0, and the next y_valid comes 32 cycles later.
- Reset mid-MAC: assert reset at cycle 15 of filter 0. The next cycle shows all outputs 0, busy=0, and no y_valid. A subsequent impulse gives responses identical to those from power-on.
- Wrap-around: feed 40 samples of a ramp x=n mod 128 and compare each y against a software 31-tap model. This exercises wp wrapping past 31 to 0.
